// File: rtl/impact_bank_access_seq.sv
// Access sequencer for one IMPACT SRAM bank: precharge, timed word-line pulse,
// then bitline drive (write) or sense (read), with valid/ready request/response.
module impact_bank_access_seq #(
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 16,
    parameter int SEL_W         = 10,
    parameter int PRECHARGE_CYC = 2,
    parameter int WL_CYC        = 3,
    parameter logic [SEL_W-1:0] IDLE_SEL = 10'h200
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [SEL_W-1:0]  sel_o,
    output logic [DATA_W-1:0] bl_o,
    output logic [DATA_W-1:0] blb_o,
    output logic [DATA_W-1:0] bl_oe,
    output logic [DATA_W-1:0] blb_oe,
    input  logic [DATA_W-1:0] bl_i,
    input  logic [DATA_W-1:0] blb_i
);

    localparam int MAX_CYC = (PRECHARGE_CYC > WL_CYC) ? PRECHARGE_CYC : WL_CYC;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(PRECHARGE_CYC - 1);
    localparam logic [CNT_W-1:0] WL_LD  = CNT_W'(WL_CYC - 1);

    typedef enum logic [1:0] {IDLE, PRECH, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic [SEL_W-1:0]    sel_d;
    logic [DATA_W-1:0]   bl_d, blb_d, bl_oe_d, blb_oe_d;
    logic [SEL_W-1:0]    acc_sel;

    assign req_ready = (state_q == IDLE);
    assign acc_sel   = {{(SEL_W-ADDR_W){1'b0}}, addr_q};

    // Pad values are computed for the next state and registered with it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        sel_d       = sel_o;
        bl_d        = bl_o;
        blb_d       = blb_o;
        bl_oe_d     = bl_oe;
        blb_oe_d    = blb_oe;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d  = PRECH;
                    cnt_d    = PRE_LD;
                    we_d     = req_we;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    sel_d    = IDLE_SEL;
                    bl_d     = '1;
                    blb_d    = '1;
                    bl_oe_d  = '1;
                    blb_oe_d = '1;
                end
            end
            PRECH: begin
                if (cnt_q == '0) begin
                    state_d  = ACCESS;
                    cnt_d    = WL_LD;
                    sel_d    = acc_sel;
                    bl_d     = we_q ? wdata_q : '0;
                    blb_d    = we_q ? ~wdata_q : '0;
                    bl_oe_d  = {DATA_W{we_q}};
                    blb_oe_d = {DATA_W{we_q}};
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    cnt_d       = '0;
                    sel_d       = IDLE_SEL;
                    bl_d        = '0;
                    blb_d       = '0;
                    bl_oe_d     = '0;
                    blb_oe_d    = '0;
                    rsp_rdata_d = we_q ? '0 : (bl_i & ~blb_i);
                    rsp_err_d   = ~we_q & (|(~(bl_i ^ blb_i)));
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                // One turnaround cycle with the pads released before valid rises.
                if (rsp_valid && rsp_ready) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            sel_o     <= IDLE_SEL;
            bl_o      <= '0;
            blb_o     <= '0;
            bl_oe     <= '0;
            blb_oe    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            sel_o     <= sel_d;
            bl_o      <= bl_d;
            blb_o     <= blb_d;
            bl_oe     <= bl_oe_d;
            blb_oe    <= blb_oe_d;
        end
    end

endmodule

// File: tb/tb_impact_bank_access_seq.sv
// Directed bench for impact_bank_access_seq with a small bitline bank model.
// Each task drives one scenario and checks its own expectations inline.
module tb_impact_bank_access_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  sel_o;
    logic [15:0] bl_o, blb_o, bl_oe, blb_oe;
    logic [15:0] bl_i, blb_i;

    logic [15:0] mem [32];
    logic        load_en = 1'b0;
    logic [4:0]  load_a = '0;
    logic [15:0] load_d = '0;
    logic        force_err = 1'b0;

    int checks = 0;
    int errors = 0;

    impact_bank_access_seq dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sel_o(sel_o), .bl_o(bl_o), .blb_o(blb_o),
        .bl_oe(bl_oe), .blb_oe(blb_oe), .bl_i(bl_i), .blb_i(blb_i)
    );

    always #5 clk = ~clk;

    // Bank model: a driven word line with driven bitlines stores, a floating pair senses.
    always @(posedge clk) begin
        if (load_en)
            mem[load_a] <= load_d;
        else if (sel_o[9:5] == 5'd0 && &bl_oe && &blb_oe)
            mem[sel_o[4:0]] <= bl_o;
    end

    always_comb begin
        bl_i  = 16'hFFFF;
        blb_i = 16'hFFFF;
        if (!force_err && sel_o[9:5] == 5'd0 && bl_oe == '0 && blb_oe == '0) begin
            bl_i  = mem[sel_o[4:0]];
            blb_i = ~mem[sel_o[4:0]];
        end
    end

    task automatic load(input logic [4:0] a, input logic [15:0] d);
        load_en = 1'b1; load_a = a; load_d = d;
        @(posedge clk); #1 load_en = 1'b0;
    endtask

    // Issues one request from a negedge and observes every cycle after the accept edge.
    task automatic txn(input logic we, input logic [4:0] a, input logic [15:0] d,
                       output int lat, output int n_pre, output int n_acc,
                       output int n_bad, output logic [15:0] rd, output logic err);
        lat = -1; n_pre = 0; n_acc = 0; n_bad = 0; rd = 'x; err = 'x;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(posedge clk); #1 req_valid = 1'b0;
        for (int k = 0; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (sel_o == 10'h200 && &bl_oe && &blb_oe && &bl_o && &blb_o) n_pre++;
            if (sel_o == {5'd0, a}) begin
                n_acc++;
                if (we ? (bl_o !== d || blb_o !== ~d || bl_oe !== 16'hFFFF
                          || blb_oe !== 16'hFFFF)
                       : (bl_oe !== 16'h0 || blb_oe !== 16'h0))
                    n_bad++;
            end
            if (rsp_valid === 1'b1) begin
                lat = k; rd = rsp_rdata; err = rsp_err;
            end
        end
        if (lat >= 0 && rsp_ready) begin
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        load(5'd7, 16'hA5C3);
        load(5'd0, 16'h0C0F);
        load(5'd31, 16'h0000);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp ready=%b valid=%b rdata=%h err=%b want 1 0 0000 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        checks++;
        if (sel_o !== 10'h200 || bl_o !== 16'h0 || blb_o !== 16'h0
            || bl_oe !== 16'h0 || blb_oe !== 16'h0) begin
            errors++;
            $display("FAIL reset_pads sel=%h bl=%h blb=%h oe=%h/%h want 200 0 0 0/0",
                     sel_o, bl_o, blb_o, bl_oe, blb_oe);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || sel_o !== 10'h200 || bl_oe !== 16'h0) begin
            errors++;
            $display("FAIL reset_release ready=%b sel=%h oe=%h want 1 200 0000",
                     req_ready, sel_o, bl_oe);
        end
    endtask

    task automatic test_read;
        int lat, np, na, nb; logic [15:0] rd; logic er;
        txn(1'b0, 5'd7, 16'h0, lat, np, na, nb, rd, er);
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL read_latency got %0d want 6", lat); end
        checks++;
        if (np !== 2) begin errors++; $display("FAIL read_precharge got %0d want 2", np); end
        checks++;
        if (na !== 3 || nb !== 0) begin
            errors++; $display("FAIL read_wl cycles=%0d bad=%0d want 3 0", na, nb);
        end
        checks++;
        if (rd !== 16'hA5C3 || er !== 1'b0) begin
            errors++; $display("FAIL read_data got %h err=%b want a5c3 0", rd, er);
        end
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL read_idle ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_write;
        int lat, np, na, nb; logic [15:0] rd; logic er;
        txn(1'b1, 5'd31, 16'h1234, lat, np, na, nb, rd, er);
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL write_latency got %0d want 6", lat); end
        checks++;
        if (np !== 2) begin errors++; $display("FAIL write_precharge got %0d want 2", np); end
        checks++;
        if (na !== 3 || nb !== 0) begin
            errors++; $display("FAIL write_drive cycles=%0d bad=%0d want 3 0", na, nb);
        end
        checks++;
        if (rd !== 16'h0 || er !== 1'b0) begin
            errors++; $display("FAIL write_rsp got %h err=%b want 0000 0", rd, er);
        end
        txn(1'b0, 5'd31, 16'h0, lat, np, na, nb, rd, er);
        checks++;
        if (lat !== 6 || rd !== 16'h1234 || er !== 1'b0) begin
            errors++; $display("FAIL write_readback lat=%0d got %h err=%b want 6 1234 0", lat, rd, er);
        end
    endtask

    task automatic test_backpressure;
        int lat, np, na, nb; logic [15:0] rd; logic er;
        int bad;
        rsp_ready = 1'b0;
        txn(1'b0, 5'd7, 16'h0, lat, np, na, nb, rd, er);
        checks++;
        if (lat !== 6 || rd !== 16'hA5C3) begin
            errors++; $display("FAIL bp_first lat=%0d got %h want 6 a5c3", lat, rd);
        end
        bad = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hA5C3 || rsp_err !== 1'b0
                || req_ready !== 1'b0 || sel_o !== 10'h200 || bl_oe !== 16'h0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL bp_hold bad_cycles=%0d want 0", bad); end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release valid=%b ready=%b want 0 1", rsp_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || sel_o !== 10'h200 || bl_oe !== 16'h0) begin
            errors++; $display("FAIL bp_no_accept ready=%b sel=%h oe=%h want 1 200 0000",
                               req_ready, sel_o, bl_oe);
        end
    endtask

    task automatic test_sense_err;
        int lat, np, na, nb; logic [15:0] rd; logic er;
        force_err = 1'b1;
        txn(1'b0, 5'd7, 16'h0, lat, np, na, nb, rd, er);
        force_err = 1'b0;
        checks++;
        if (lat !== 6 || rd !== 16'h0000 || er !== 1'b1) begin
            errors++; $display("FAIL sense_err lat=%0d got %h err=%b want 6 0000 1", lat, rd, er);
        end
    endtask

    task automatic test_back_to_back;
        int lat, np, na, nb; logic [15:0] rd; logic er;
        txn(1'b1, 5'd5, 16'h0F0F, lat, np, na, nb, rd, er);
        checks++;
        if (req_ready !== 1'b1 || lat !== 6) begin
            errors++; $display("FAIL b2b_idle ready=%b lat=%0d want 1 6", req_ready, lat);
        end
        txn(1'b0, 5'd5, 16'h0, lat, np, na, nb, rd, er);
        checks++;
        if (lat !== 6 || np !== 2 || na !== 3 || rd !== 16'h0F0F || er !== 1'b0) begin
            errors++;
            $display("FAIL b2b_read lat=%0d pre=%0d wl=%0d got %h err=%b want 6 2 3 0f0f 0",
                     lat, np, na, rd, er);
        end
    endtask

    task automatic test_reset_mid;
        int lat, np, na, nb; logic [15:0] rd; logic er;
        int seen;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd9;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sel_o !== 10'h009 || bl_oe !== 16'h0) begin
            errors++; $display("FAIL mid_access sel=%h oe=%h want 009 0000", sel_o, bl_oe);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sel_o !== 10'h200 || bl_oe !== 16'h0 || blb_oe !== 16'h0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset sel=%h oe=%h/%h valid=%b want 200 0/0 0",
                               sel_o, bl_oe, blb_oe, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || sel_o !== 10'h200) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mid_dropped bad_cycles=%0d want 0", seen); end
        txn(1'b0, 5'd0, 16'h0, lat, np, na, nb, rd, er);
        checks++;
        if (lat !== 6 || np !== 2 || na !== 3 || rd !== 16'h0C0F || er !== 1'b0) begin
            errors++;
            $display("FAIL mid_recover lat=%0d pre=%0d wl=%0d got %h err=%b want 6 2 3 0c0f 0",
                     lat, np, na, rd, er);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_backpressure();
        test_sense_err();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
